// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cpu_pkg                                                          |
// | Brief   : Opcode, ALU-function and control-state encodings for the CPU.    |
// | Rev     : 1.0  initial multi-cycle control release                         |
// +----------------------------------------------------------------------------+
package cpu_pkg;

    localparam logic [7:0] c_op_add   = 8'h00;
    localparam logic [7:0] c_op_sub   = 8'h01;
    localparam logic [7:0] c_op_and   = 8'h02;
    localparam logic [7:0] c_op_or    = 8'h03;
    localparam logic [7:0] c_op_mov   = 8'h04;
    localparam logic [7:0] c_op_loadi = 8'h05;
    localparam logic [7:0] c_op_j     = 8'h06;
    localparam logic [7:0] c_op_beq   = 8'h07;
    localparam logic [7:0] c_op_bne   = 8'h08;
    localparam logic [7:0] c_op_lwd   = 8'h09;
    localparam logic [7:0] c_op_swd   = 8'h0A;

    localparam logic [2:0] c_alu_fwd = 3'b000;
    localparam logic [2:0] c_alu_add = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;

    typedef enum logic [2:0] {
        st_fetch = 3'd0,
        st_exec  = 3'd1,
        st_mem   = 3'd2,
        st_wb    = 3'd3,
        st_halt  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_op_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cpu_op_decoder                                                   |
// | Brief   : Combinational opcode decode into datapath control attributes.    |
// | Rev     : 1.0  initial multi-cycle control release                         |
// +----------------------------------------------------------------------------+
module cpu_op_decoder
    import cpu_pkg::*;
#(
    parameter int OP_W    = 8,
    parameter int ALUOP_W = 3
) (
    input  logic [OP_W-1:0]    i_op,
    output logic               o_legal,
    output logic               o_twoscomp_sel,
    output logic               o_imm_sel,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic               o_is_mem,
    output logic               o_is_load,
    output logic               o_is_branch,
    output logic               o_is_jump,
    output logic               o_writes_reg
);

    always_comb begin
        // Legal opcodes form the contiguous range ADD..SWD.
        o_legal        = (i_op <= OP_W'(c_op_swd));
        o_twoscomp_sel = 1'b0;
        o_imm_sel      = 1'b0;
        o_alu_op       = ALUOP_W'(c_alu_fwd);
        o_is_mem       = 1'b0;
        o_is_load      = 1'b0;
        o_is_branch    = 1'b0;
        o_is_jump      = 1'b0;
        o_writes_reg   = 1'b0;
        case (i_op)
            OP_W'(c_op_add): begin
                o_alu_op     = ALUOP_W'(c_alu_add);
                o_writes_reg = 1'b1;
            end
            OP_W'(c_op_sub): begin
                o_twoscomp_sel = 1'b1;
                o_alu_op       = ALUOP_W'(c_alu_add);
                o_writes_reg   = 1'b1;
            end
            OP_W'(c_op_and): begin
                o_alu_op     = ALUOP_W'(c_alu_and);
                o_writes_reg = 1'b1;
            end
            OP_W'(c_op_or): begin
                o_alu_op     = ALUOP_W'(c_alu_or);
                o_writes_reg = 1'b1;
            end
            OP_W'(c_op_mov): begin
                o_writes_reg = 1'b1;
            end
            OP_W'(c_op_loadi): begin
                o_imm_sel    = 1'b1;
                o_writes_reg = 1'b1;
            end
            OP_W'(c_op_j): begin
                o_is_jump = 1'b1;
            end
            OP_W'(c_op_beq), OP_W'(c_op_bne): begin
                o_twoscomp_sel = 1'b1;
                o_alu_op       = ALUOP_W'(c_alu_add);
                o_is_branch    = 1'b1;
            end
            OP_W'(c_op_lwd): begin
                o_is_mem     = 1'b1;
                o_is_load    = 1'b1;
                o_writes_reg = 1'b1;
            end
            OP_W'(c_op_swd): begin
                o_is_mem = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_control_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cpu_control_fsm                                                  |
// | Brief   : Multi-cycle FETCH/EXEC/MEM/WB control unit with halt on faults.  |
// | Rev     : 1.0  initial multi-cycle control release                         |
// +----------------------------------------------------------------------------+
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int OP_W        = 8,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 0,
    parameter int TMO_W       = 8
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [OP_W-1:0]    OP,
    input  logic               INSTR_VALID,
    input  logic               ZERO,
    input  logic               DMEM_BUSYWAIT,
    output logic               PC_EN,
    output logic               TWOSCOMP_SEL,
    output logic               IMM_SEL,
    output logic               REG_WRITE_EN,
    output logic [ALUOP_W-1:0] ALU_OP,
    output logic               JUMP,
    output logic               BRANCH_TAKEN,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic               WB_SEL,
    output logic               ILLEGAL,
    output logic               TIMEOUT
);

    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_t            r_state;
    logic [OP_W-1:0]   r_op_q;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic              r_illegal;
    logic              r_timeout;

    logic               w_legal;
    logic               w_twoscomp_sel;
    logic               w_imm_sel;
    logic [ALUOP_W-1:0] w_alu_op;
    logic               w_is_mem;
    logic               w_is_load;
    logic               w_is_branch;
    logic               w_is_jump;
    logic               w_writes_reg;
    logic               w_fetch_legal;
    logic               w_tmo_hit;
    logic               w_exec;
    logic               w_mem;
    logic               w_wb;

    cpu_op_decoder #(
        .OP_W    (OP_W),
        .ALUOP_W (ALUOP_W)
    ) u_dec (
        .i_op           (r_op_q),
        .o_legal        (w_legal),
        .o_twoscomp_sel (w_twoscomp_sel),
        .o_imm_sel      (w_imm_sel),
        .o_alu_op       (w_alu_op),
        .o_is_mem       (w_is_mem),
        .o_is_load      (w_is_load),
        .o_is_branch    (w_is_branch),
        .o_is_jump      (w_is_jump),
        .o_writes_reg   (w_writes_reg)
    );

    assign w_fetch_legal = (OP <= OP_W'(c_op_swd));
    assign w_tmo_hit     = (MEM_TIMEOUT != 0) && (r_tmo_cnt == c_tmo_last);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= st_fetch;
            r_op_q    <= '0;
            r_tmo_cnt <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                st_fetch: begin
                    if (INSTR_VALID) begin
                        r_op_q <= OP;
                        if (w_fetch_legal) begin
                            r_state <= st_exec;
                        end else begin
                            r_illegal <= 1'b1;
                            r_state   <= st_halt;
                        end
                    end
                end
                st_exec: begin
                    if (w_is_mem) begin
                        r_tmo_cnt <= '0;
                        r_state   <= st_mem;
                    end else begin
                        r_state <= st_fetch;
                    end
                end
                st_mem: begin
                    // A completing access wins over a timeout on the same edge.
                    if (!DMEM_BUSYWAIT) begin
                        r_state <= w_is_load ? st_wb : st_fetch;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                        if (w_tmo_hit) begin
                            r_timeout <= 1'b1;
                            r_state   <= st_halt;
                        end
                    end
                end
                st_wb:   r_state <= st_fetch;
                st_halt: r_state <= st_halt;
                default: r_state <= st_fetch;
            endcase
        end
    end

    assign w_exec = (r_state == st_exec) && w_legal;
    assign w_mem  = (r_state == st_mem);
    assign w_wb   = (r_state == st_wb);

    always_comb begin
        PC_EN        = (w_exec && !w_is_mem) || (w_mem && !w_is_load && !DMEM_BUSYWAIT) || w_wb;
        TWOSCOMP_SEL = w_exec && w_twoscomp_sel;
        IMM_SEL      = w_exec && w_imm_sel;
        REG_WRITE_EN = (w_exec && w_writes_reg && !w_is_mem) || w_wb;
        ALU_OP       = w_exec ? w_alu_op : '0;
        JUMP         = w_exec && w_is_jump;
        BRANCH_TAKEN = w_exec && w_is_branch && ((r_op_q == OP_W'(c_op_bne)) ? !ZERO : ZERO);
        MEM_READ     = w_mem && w_is_load;
        MEM_WRITE    = w_mem && !w_is_load;
        WB_SEL       = w_wb;
        ILLEGAL      = r_illegal;
        TIMEOUT      = r_timeout;
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_cpu_control_fsm                                               |
// | Brief   : Randomized self-checking bench with instruction-level model.     |
// | Rev     : 1.0  initial multi-cycle control release                         |
// +----------------------------------------------------------------------------+
module tb_cpu_control_fsm;

    localparam int c_tmo = 4;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [7:0] OP = 8'h00;
    logic       INSTR_VALID = 1'b0;
    logic       ZERO = 1'b0;
    logic       DMEM_BUSYWAIT = 1'b0;
    logic       PC_EN, TWOSCOMP_SEL, IMM_SEL, REG_WRITE_EN;
    logic [2:0] ALU_OP;
    logic       JUMP, BRANCH_TAKEN, MEM_READ, MEM_WRITE, WB_SEL, ILLEGAL, TIMEOUT;

    int n_tests = 0;
    int n_fail  = 0;
    int pc_pulses = 0;
    int retired   = 0;
    logic exp_ill = 1'b0;
    logic exp_to  = 1'b0;

    cpu_control_fsm #(
        .OP_W        (8),
        .ALUOP_W     (3),
        .MEM_TIMEOUT (c_tmo),
        .TMO_W       (8)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .OP            (OP),
        .INSTR_VALID   (INSTR_VALID),
        .ZERO          (ZERO),
        .DMEM_BUSYWAIT (DMEM_BUSYWAIT),
        .PC_EN         (PC_EN),
        .TWOSCOMP_SEL  (TWOSCOMP_SEL),
        .IMM_SEL       (IMM_SEL),
        .REG_WRITE_EN  (REG_WRITE_EN),
        .ALU_OP        (ALU_OP),
        .JUMP          (JUMP),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .WB_SEL        (WB_SEL),
        .ILLEGAL       (ILLEGAL),
        .TIMEOUT       (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (PC_EN) pc_pulses++;

    // Bit order: pc tw imm we alu[2:0] j br rd wr wb ill to
    function automatic logic [13:0] outs_now();
        return {PC_EN, TWOSCOMP_SEL, IMM_SEL, REG_WRITE_EN, ALU_OP, JUMP,
                BRANCH_TAKEN, MEM_READ, MEM_WRITE, WB_SEL, ILLEGAL, TIMEOUT};
    endfunction

    function automatic logic [13:0] flags();
        return {12'b0, exp_ill, exp_to};
    endfunction

    // Expected EXEC-cycle controls straight from the instruction table.
    function automatic logic [13:0] exec_exp(input logic [7:0] op, input logic z);
        case (op)
            8'h00:   return 14'b1001_001_0_0_000_00;
            8'h01:   return 14'b1101_001_0_0_000_00;
            8'h02:   return 14'b1001_010_0_0_000_00;
            8'h03:   return 14'b1001_011_0_0_000_00;
            8'h04:   return 14'b1001_000_0_0_000_00;
            8'h05:   return 14'b1011_000_0_0_000_00;
            8'h06:   return 14'b1000_000_1_0_000_00;
            8'h07:   return {4'b1100, 3'b001, 1'b0, z, 5'b00000};
            8'h08:   return {4'b1100, 3'b001, 1'b0, !z, 5'b00000};
            default: return 14'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [13:0] exp);
        @(negedge CLK);
        check(tag, 32'(outs_now()), 32'(exp));
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        #1;
        check("reset_async", 32'(outs_now()), 32'd0);
        @(negedge CLK);
        check("reset_hold", 32'(outs_now()), 32'd0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        exp_ill = 1'b0;
        exp_to  = 1'b0;
    endtask

    task automatic run_instr(input logic [7:0] op, input logic z, input int busy_n, input int stall_n);
        logic busy;
        for (int s = 0; s < stall_n; s++) begin
            INSTR_VALID = 1'b0; OP = 8'($urandom);
            ZERO = 1'($urandom); DMEM_BUSYWAIT = 1'($urandom);
            cyc("fetch_stall", flags());
        end
        INSTR_VALID = 1'b1; OP = op;
        cyc("fetch", flags());
        INSTR_VALID = 1'($urandom); OP = 8'($urandom_range(0, 10));
        if (op > 8'h0A) begin
            exp_ill = 1'b1;
            for (int h = 0; h < 3; h++) cyc("halt_illegal", flags());
            return;
        end
        ZERO = z;
        cyc("exec", exec_exp(op, z) | flags());
        if (op == 8'h09 || op == 8'h0A) begin
            for (int k = 0; k < c_tmo; k++) begin
                busy = (k < busy_n);
                DMEM_BUSYWAIT = busy;
                if (op == 8'h09) cyc("mem_rd", 14'b0000_000_0_0_100_00 | flags());
                else cyc("mem_wr", {!busy, 13'b000_000_0_0_010_00} | flags());
                if (!busy) break;
                if (k == c_tmo - 1) begin
                    exp_to = 1'b1;
                    DMEM_BUSYWAIT = 1'b1; INSTR_VALID = 1'b1;
                    for (int h = 0; h < 3; h++) cyc("halt_timeout", flags());
                    return;
                end
            end
            DMEM_BUSYWAIT = 1'($urandom);
            if (op == 8'h09) cyc("wb", 14'b1001_000_0_0_001_00 | flags());
        end
        retired++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int p0;
        INSTR_VALID = 1'b1;
        @(posedge CLK);
        #1;
        do_reset();

        p0 = pc_pulses;
        run_instr(8'h00, 1'b0, 0, 0);
        run_instr(8'h01, 1'b0, 0, 0);
        run_instr(8'h05, 1'b0, 0, 0);
        @(negedge CLK);
        check("alu_seq_pc_pulses", 32'(pc_pulses - p0), 32'd3);
        @(posedge CLK); #1;

        run_instr(8'h07, 1'b1, 0, 1);
        run_instr(8'h08, 1'b1, 0, 0);
        run_instr(8'h07, 1'b0, 0, 0);
        run_instr(8'h08, 1'b0, 0, 2);
        run_instr(8'h06, 1'b0, 0, 0);
        run_instr(8'h09, 1'b0, 3, 0);
        run_instr(8'h0A, 1'b0, 1, 0);
        run_instr(8'h0A, 1'b0, 0, 0);

        for (int i = 0; i < 60; i++)
            run_instr(8'($urandom_range(0, 10)), 1'($urandom), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)));

        @(negedge CLK);
        check("pc_once_per_instr", 32'(pc_pulses), 32'(retired));
        @(posedge CLK); #1;

        // SWD interrupted by reset in its first busy MEM cycle.
        INSTR_VALID = 1'b1; OP = 8'h0A;
        cyc("rst_mid_fetch", 14'b0);
        INSTR_VALID = 1'b0;
        cyc("rst_mid_exec", 14'b0);
        DMEM_BUSYWAIT = 1'b1;
        @(negedge CLK);
        check("rst_mid_memwr", 32'(MEM_WRITE), 32'd1);
        #2;
        do_reset();
        p0 = pc_pulses;
        run_instr(8'h04, 1'b0, 0, 0);
        @(negedge CLK);
        check("after_reset_pc", 32'(pc_pulses - p0), 32'd1);
        @(posedge CLK); #1;

        p0 = pc_pulses;
        run_instr(8'h0A, 1'b0, 100, 0);
        @(negedge CLK);
        check("timeout_no_pc", 32'(pc_pulses - p0), 32'd0);
        @(posedge CLK); #1;
        do_reset();
        run_instr(8'h02, 1'b0, 0, 0);

        p0 = pc_pulses;
        run_instr(8'hFF, 1'b0, 0, 0);
        run_instr(8'($urandom_range(11, 254)), 1'b0, 0, 0);
        @(negedge CLK);
        check("illegal_no_pc", 32'(pc_pulses - p0), 32'd0);
        @(posedge CLK); #1;
        do_reset();
        run_instr(8'h03, 1'b0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
